compare_sched: RTL and testbench
================================

# compare_sched

Search scheduler for the 13-segment compare engine array. Shares one compare-engine issue slot between NREQ search requesters using round-robin valid/ready arbitration, and tracks every in-flight search through the fixed engine latency so each result returns to the requester that issued it. It also quiesces the array for table-maintenance updates: it blocks new issues, drains the pipeline, then grants the update port exclusive access.

## Interface
Parameters:
- KWID, 104, search key width
- NREQ, 4, number of search requesters
- IDW, 2, requester ID width (clog2 NREQ)
- LAT, 2, compare-engine latency, cycles from o_Eng_Valid to i_Eng_Result valid
- RWID, 130, engine result width (13 segments x SEGWID 10)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- i_Req_Valid  input  NREQ  per-requester search request
- i_Req_Key  input  NREQ*KWID  packed keys; requester i occupies bits [i*KWID +: KWID]
- o_Req_Ready  output  NREQ  one-hot grant, combinational
- o_Eng_Valid  output  1  registered issue strobe to the engine array
- o_Eng_Key  output  KWID  registered key to the engine array
- i_Eng_Result  input  RWID  concatenated engine compare results
- o_Rsp_Valid  output  1  registered response strobe, no backpressure
- o_Rsp_Id  output  IDW  requester index owning the response
- o_Rsp_Data  output  RWID  registered copy of i_Eng_Result
- i_Upd_Req  input  1  level request for exclusive table-update access
- o_Upd_Grant  output  1  registered; high means the array is idle and owned by the updater
- o_Inflight  output  3  current count of in-flight searches

## Operation
- States: RUN, DRAIN, UPD. Reset state is RUN.
- RUN, arbitration:
  - Round-robin pointer ptr, reset to 0.
  - Grant goes to the first requester with i_Req_Valid=1, searching from index ptr upward with wrap.
  - o_Req_Ready is one-hot for that requester only, and is asserted only when state=RUN and i_Upd_Req=0; otherwise all zero.
  - On a handshake (valid and ready both high), ptr becomes (granted+1) mod NREQ. With no handshake, ptr holds.
- Issue on a handshake: the next edge loads o_Eng_Key with the granted key, sets o_Eng_Valid=1 and pushes the granted ID with valid=1 into a tag shift register of depth LAT. A cycle without a handshake pushes valid=0 and drives o_Eng_Valid=0.
- Retire: when the tag at depth LAT is valid, the next edge sets o_Rsp_Valid=1 and registers o_Rsp_Id from the tag and o_Rsp_Data from i_Eng_Result.
- o_Inflight counts handshakes not yet retired. It increments on handshake and decrements on retire; both in the same cycle leave it unchanged. Maximum value is LAT+1.
- RUN -> DRAIN when i_Upd_Req=1; grants stop in the same cycle.
- DRAIN -> UPD when o_Inflight=0 and i_Upd_Req=1.
- DRAIN -> RUN if i_Upd_Req drops before the drain completes.
- UPD: o_Upd_Grant=1. When i_Upd_Req drops, go to RUN; o_Upd_Grant falls on the next edge and grants resume that cycle.
- Responses already in flight always complete during DRAIN; none are dropped.

## Timing
- Reset values: o_Eng_Valid 0, o_Eng_Key 0, o_Rsp_Valid 0, o_Rsp_Id 0, o_Rsp_Data 0, o_Upd_Grant 0, o_Inflight 0, ptr 0, all tags invalid.
- o_Req_Ready is held at 0 while rst is low.
- Handshake at cycle c: o_Eng_Valid at c+1, engine result sampled at c+1+LAT, o_Rsp_Valid at c+2+LAT (c+4 by default).
- Throughput is one search per cycle; back-to-back handshakes give back-to-back responses in issue order.
- Update latency: i_Upd_Req sampled high at cycle u gives o_Upd_Grant at u+1 if o_Inflight=0 at u, otherwise one cycle after the last retire.
- Asynchronous reset mid-operation clears all in-flight tags; no response is ever produced for a search issued before reset.

## Test plan
- Single search: requester 2 alone, key 0x0A…01, handshake at cycle 10 -> o_Eng_Valid at 11 with that key; with i_Eng_Result=0x155 at cycle 13, o_Rsp_Valid at 14 with Id=2 and Data=0x155.
- Fairness: all four requesters held valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; responses return in the same order, Ids matching.
- Pointer wrap: ptr=3, only requesters 3 and 0 valid -> grants 3, 0, 3, 0 alternately.
- Drain: issue 3 back-to-back searches, then raise i_Upd_Req the following cycle -> o_Req_Ready=0 immediately, all 3 responses delivered, o_Upd_Grant rises the cycle after o_Inflight reaches 0; dropping i_Upd_Req -> grant falls and arbitration resumes.
- Abort: i_Upd_Req pulsed for 1 cycle while o_Inflight=2 -> state returns to RUN, o_Upd_Grant never asserts.
- Reset mid-flight: assert rst low with o_Inflight=3 -> all outputs return to reset values, and no o_Rsp_Valid pulse appears after reset release.

Source files
------------

// File: rtl/compare_sched.sv
// Search scheduler for the 13-segment compare engine array: round-robin issue
// arbitration, in-flight tag tracking and drain/quiesce for table updates.
module compare_sched #(
  parameter int unsigned KWID = 104,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2,
  parameter int unsigned LAT  = 2,
  parameter int unsigned RWID = 130
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      i_Req_Valid,
  input  logic [NREQ*KWID-1:0] i_Req_Key,
  output logic [NREQ-1:0]      o_Req_Ready,
  output logic                 o_Eng_Valid,
  output logic [KWID-1:0]      o_Eng_Key,
  input  logic [RWID-1:0]      i_Eng_Result,
  output logic                 o_Rsp_Valid,
  output logic [IDW-1:0]       o_Rsp_Id,
  output logic [RWID-1:0]      o_Rsp_Data,
  input  logic                 i_Upd_Req,
  output logic                 o_Upd_Grant,
  output logic [2:0]           o_Inflight
);

  localparam int unsigned CNTW = 3;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_UPD} state_e;

  state_e                  state_q, state_d;
  logic [IDW-1:0]          ptr_q, ptr_d;
  logic                    eng_valid_q, eng_valid_d;
  logic [KWID-1:0]         eng_key_q, eng_key_d;
  logic [IDW-1:0]          eng_id_q, eng_id_d;
  logic [LAT-1:0]          tag_vld_q, tag_vld_d;
  logic [LAT-1:0][IDW-1:0] tag_id_q, tag_id_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]          rsp_id_q, rsp_id_d;
  logic [RWID-1:0]         rsp_data_q, rsp_data_d;
  logic                    upd_grant_q, upd_grant_d;
  logic [CNTW-1:0]         inflight_q, inflight_d;

  logic                    gnt_found;
  logic [IDW-1:0]          gnt_id;
  logic                    grant_en;
  logic                    hs;
  logic                    retire;

  // Round-robin search starting at ptr_q, wrapping at NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!gnt_found && i_Req_Valid[IDW'((32'(ptr_q) + i) % NREQ)]) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'((32'(ptr_q) + i) % NREQ);
      end
    end
  end

  assign grant_en    = rst && (state_q == ST_RUN) && !i_Upd_Req;
  assign hs          = grant_en && gnt_found;
  assign o_Req_Ready = hs ? (NREQ'(1) << gnt_id) : '0;
  assign retire      = tag_vld_q[LAT-1];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    eng_valid_d = hs;
    eng_key_d   = eng_key_q;
    eng_id_d    = eng_id_q;
    tag_vld_d   = LAT'({tag_vld_q, eng_valid_q});
    tag_id_d    = (LAT*IDW)'({tag_id_q, eng_id_q});
    rsp_valid_d = retire;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    inflight_d  = inflight_q;

    if (hs) begin
      ptr_d     = (32'(gnt_id) == NREQ - 1) ? '0 : gnt_id + IDW'(1);
      eng_key_d = i_Req_Key[32'(gnt_id)*KWID +: KWID];
      eng_id_d  = gnt_id;
    end

    if (retire) begin
      rsp_id_d   = tag_id_q[LAT-1];
      rsp_data_d = i_Eng_Result;
    end

    case ({hs, retire})
      2'b10:   inflight_d = inflight_q + CNTW'(1);
      2'b01:   inflight_d = inflight_q - CNTW'(1);
      default: inflight_d = inflight_q;
    endcase

    // An empty pipeline lets RUN hand the array straight to the updater.
    case (state_q)
      ST_RUN: begin
        if (i_Upd_Req) state_d = (inflight_q == '0) ? ST_UPD : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!i_Upd_Req)              state_d = ST_RUN;
        else if (inflight_q == '0)   state_d = ST_UPD;
      end
      ST_UPD: begin
        if (!i_Upd_Req) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    upd_grant_d = (state_d == ST_UPD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      ptr_q       <= '0;
      eng_valid_q <= 1'b0;
      eng_key_q   <= '0;
      eng_id_q    <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      upd_grant_q <= 1'b0;
      inflight_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      eng_valid_q <= eng_valid_d;
      eng_key_q   <= eng_key_d;
      eng_id_q    <= eng_id_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      upd_grant_q <= upd_grant_d;
      inflight_q  <= inflight_d;
    end
  end

  assign o_Eng_Valid = eng_valid_q;
  assign o_Eng_Key   = eng_key_q;
  assign o_Rsp_Valid = rsp_valid_q;
  assign o_Rsp_Id    = rsp_id_q;
  assign o_Rsp_Data  = rsp_data_q;
  assign o_Upd_Grant = upd_grant_q;
  assign o_Inflight  = inflight_q;

endmodule

// File: tb/tb_compare_sched.sv
// Directed bench for compare_sched: arbitration order, issue/retire timing,
// drain/update handoff, abort and mid-flight reset.
module tb_compare_sched;

  localparam int unsigned KWID = 104;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;
  localparam int unsigned LAT  = 2;
  localparam int unsigned RWID = 130;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      i_Req_Valid;
  logic [NREQ*KWID-1:0] i_Req_Key;
  logic [NREQ-1:0]      o_Req_Ready;
  logic                 o_Eng_Valid;
  logic [KWID-1:0]      o_Eng_Key;
  logic [RWID-1:0]      i_Eng_Result;
  logic                 o_Rsp_Valid;
  logic [IDW-1:0]       o_Rsp_Id;
  logic [RWID-1:0]      o_Rsp_Data;
  logic                 i_Upd_Req;
  logic                 o_Upd_Grant;
  logic [2:0]           o_Inflight;

  int passed;
  int total;
  int cyc;

  compare_sched #(.KWID(KWID), .NREQ(NREQ), .IDW(IDW), .LAT(LAT), .RWID(RWID)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_Req_Valid  (i_Req_Valid),
    .i_Req_Key    (i_Req_Key),
    .o_Req_Ready  (o_Req_Ready),
    .o_Eng_Valid  (o_Eng_Valid),
    .o_Eng_Key    (o_Eng_Key),
    .i_Eng_Result (i_Eng_Result),
    .o_Rsp_Valid  (o_Rsp_Valid),
    .o_Rsp_Id     (o_Rsp_Id),
    .o_Rsp_Data   (o_Rsp_Data),
    .i_Upd_Req    (i_Upd_Req),
    .o_Upd_Grant  (o_Upd_Grant),
    .o_Inflight   (o_Inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [KWID-1:0] key_of(input int i);
    return KWID'(32'hC0DE0000 + 32'(i) * 32'h111);
  endfunction

  function automatic logic [RWID-1:0] res_of(input int c);
    return RWID'(32'h155 + 32'(c) * 32'd13);
  endfunction

  // Advance one cycle; engine result input follows a known per-cycle pattern.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    i_Eng_Result = res_of(cyc);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    i_Req_Valid = '1;
    step();
    #1;
    total++; if (o_Req_Ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", o_Req_Ready); else passed++;
    total++; if (o_Eng_Valid !== 1'b0) $display("FAIL reset_eng_valid: got %b want 0", o_Eng_Valid); else passed++;
    total++; if (o_Eng_Key !== '0) $display("FAIL reset_eng_key: got %h want 0", o_Eng_Key); else passed++;
    total++; if (o_Rsp_Valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", o_Rsp_Valid); else passed++;
    total++; if (o_Rsp_Id !== '0) $display("FAIL reset_rsp_id: got %0d want 0", o_Rsp_Id); else passed++;
    total++; if (o_Rsp_Data !== '0) $display("FAIL reset_rsp_data: got %h want 0", o_Rsp_Data); else passed++;
    total++; if (o_Upd_Grant !== 1'b0) $display("FAIL reset_upd_grant: got %b want 0", o_Upd_Grant); else passed++;
    total++; if (o_Inflight !== 3'd0) $display("FAIL reset_inflight: got %0d want 0", o_Inflight); else passed++;
    i_Req_Valid = '0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_fairness();
    int c0;
    c0 = cyc;
    for (int k = 0; k < 12; k++) begin
      i_Req_Valid = (k < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (k < 8) begin
        total++; if (o_Req_Ready !== (4'b0001 << (k % 4))) $display("FAIL fair_ready k=%0d: got %b want %b", k, o_Req_Ready, 4'b0001 << (k % 4)); else passed++;
      end
      if (k >= 1 && k <= 8) begin
        total++; if (o_Eng_Valid !== 1'b1 || o_Eng_Key !== key_of((k - 1) % 4)) $display("FAIL fair_issue k=%0d: got v=%b key=%h want v=1 key=%h", k, o_Eng_Valid, o_Eng_Key, key_of((k - 1) % 4)); else passed++;
      end
      if (k >= 4) begin
        total++; if (o_Rsp_Valid !== 1'b1 || o_Rsp_Id !== IDW'((k - 4) % 4) || o_Rsp_Data !== res_of(c0 + k - 1)) $display("FAIL fair_rsp k=%0d: got v=%b id=%0d data=%h want v=1 id=%0d data=%h", k, o_Rsp_Valid, o_Rsp_Id, o_Rsp_Data, (k - 4) % 4, res_of(c0 + k - 1)); else passed++;
      end
      if (k == 5) begin
        total++; if (o_Inflight !== 3'd3) $display("FAIL fair_inflight_max: got %0d want 3", o_Inflight); else passed++;
      end
      step();
    end
    total++; if (o_Rsp_Valid !== 1'b0 || o_Inflight !== 3'd0) $display("FAIL fair_idle: got v=%b infl=%0d want v=0 infl=0", o_Rsp_Valid, o_Inflight); else passed++;
  endtask

  task automatic test_single();
    logic [KWID-1:0] key2;
    key2 = 104'h0A_0000000000_0000000000_00_01;
    i_Req_Key[2*KWID +: KWID] = key2;
    i_Req_Valid = 4'b0100;
    #1;
    total++; if (o_Req_Ready !== 4'b0100) $display("FAIL single_ready: got %b want 0100", o_Req_Ready); else passed++;
    step();
    i_Req_Valid = '0;
    #1;
    total++; if (o_Eng_Valid !== 1'b1 || o_Eng_Key !== key2) $display("FAIL single_issue: got v=%b key=%h want v=1 key=%h", o_Eng_Valid, o_Eng_Key, key2); else passed++;
    total++; if (o_Inflight !== 3'd1) $display("FAIL single_inflight: got %0d want 1", o_Inflight); else passed++;
    step();
    step();
    i_Eng_Result = RWID'(12'h155);
    #1;
    total++; if (o_Rsp_Valid !== 1'b0) $display("FAIL single_rsp_early: got %b want 0", o_Rsp_Valid); else passed++;
    step();
    total++; if (o_Rsp_Valid !== 1'b1 || o_Rsp_Id !== 2'd2 || o_Rsp_Data !== RWID'(12'h155)) $display("FAIL single_rsp: got v=%b id=%0d data=%h want v=1 id=2 data=155", o_Rsp_Valid, o_Rsp_Id, o_Rsp_Data); else passed++;
    step();
    total++; if (o_Rsp_Valid !== 1'b0 || o_Inflight !== 3'd0) $display("FAIL single_idle: got v=%b infl=%0d want v=0 infl=0", o_Rsp_Valid, o_Inflight); else passed++;
    i_Req_Key[2*KWID +: KWID] = key_of(2);
  endtask

  task automatic test_ptr_wrap();
    i_Req_Valid = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (o_Req_Ready !== ((k % 2 == 0) ? 4'b1000 : 4'b0001)) $display("FAIL wrap_ready k=%0d: got %b want %b", k, o_Req_Ready, (k % 2 == 0) ? 4'b1000 : 4'b0001); else passed++;
      step();
    end
    i_Req_Valid = '0;
    for (int k = 0; k < 5; k++) step();
  endtask

  task automatic test_drain();
    i_Req_Valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (o_Req_Ready !== 4'b0010) $display("FAIL drain_issue_ready k=%0d: got %b want 0010", k, o_Req_Ready); else passed++;
      step();
    end
    i_Upd_Req = 1'b1;
    for (int k = 3; k <= 8; k++) begin
      #1;
      total++; if (o_Req_Ready !== 4'b0000) $display("FAIL drain_ready k=%0d: got %b want 0000", k, o_Req_Ready); else passed++;
      total++; if (o_Inflight !== 3'((k <= 6) ? (6 - k) : 0)) $display("FAIL drain_inflight k=%0d: got %0d want %0d", k, o_Inflight, (k <= 6) ? (6 - k) : 0); else passed++;
      total++; if (o_Rsp_Valid !== ((k >= 4 && k <= 6) ? 1'b1 : 1'b0) || (k >= 4 && k <= 6 && o_Rsp_Id !== 2'd1)) $display("FAIL drain_rsp k=%0d: got v=%b id=%0d want v=%b id=1", k, o_Rsp_Valid, o_Rsp_Id, (k >= 4 && k <= 6)); else passed++;
      total++; if (o_Upd_Grant !== ((k >= 7) ? 1'b1 : 1'b0)) $display("FAIL drain_grant k=%0d: got %b want %b", k, o_Upd_Grant, k >= 7); else passed++;
      step();
    end
    i_Upd_Req = 1'b0;
    #1;
    total++; if (o_Upd_Grant !== 1'b1 || o_Req_Ready !== 4'b0000) $display("FAIL drain_release: got g=%b rdy=%b want g=1 rdy=0000", o_Upd_Grant, o_Req_Ready); else passed++;
    step();
    #1;
    total++; if (o_Upd_Grant !== 1'b0 || o_Req_Ready !== 4'b0010) $display("FAIL drain_resume: got g=%b rdy=%b want g=0 rdy=0010", o_Upd_Grant, o_Req_Ready); else passed++;
    step();
    i_Req_Valid = '0;
    for (int k = 0; k < 5; k++) step();
  endtask

  task automatic test_abort();
    i_Req_Valid = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      #1;
      total++; if (o_Req_Ready !== 4'b0001) $display("FAIL abort_issue k=%0d: got %b want 0001", k, o_Req_Ready); else passed++;
      step();
    end
    i_Req_Valid = '0;
    i_Upd_Req = 1'b1;
    #1;
    total++; if (o_Inflight !== 3'd2) $display("FAIL abort_inflight: got %0d want 2", o_Inflight); else passed++;
    step();
    i_Upd_Req = 1'b0;
    i_Req_Valid = 4'b0001;
    #1;
    total++; if (o_Req_Ready !== 4'b0000 || o_Upd_Grant !== 1'b0) $display("FAIL abort_drain: got rdy=%b g=%b want rdy=0000 g=0", o_Req_Ready, o_Upd_Grant); else passed++;
    step();
    #1;
    total++; if (o_Req_Ready !== 4'b0001 || o_Upd_Grant !== 1'b0) $display("FAIL abort_resume: got rdy=%b g=%b want rdy=0001 g=0", o_Req_Ready, o_Upd_Grant); else passed++;
    total++; if (o_Rsp_Valid !== 1'b1 || o_Rsp_Id !== 2'd0) $display("FAIL abort_rsp: got v=%b id=%0d want v=1 id=0", o_Rsp_Valid, o_Rsp_Id); else passed++;
    step();
    i_Req_Valid = '0;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++; if (o_Upd_Grant !== 1'b0) $display("FAIL abort_no_grant k=%0d: got %b want 0", k, o_Upd_Grant); else passed++;
      step();
    end
  endtask

  task automatic test_reset_midflight();
    i_Req_Valid = 4'b0010;
    for (int k = 0; k < 3; k++) step();
    i_Req_Valid = '0;
    #1;
    total++; if (o_Inflight !== 3'd3) $display("FAIL rst_pre_inflight: got %0d want 3", o_Inflight); else passed++;
    rst = 1'b0;
    i_Req_Valid = 4'b1111;
    #1;
    total++; if (o_Req_Ready !== 4'b0000) $display("FAIL rst_ready: got %b want 0000", o_Req_Ready); else passed++;
    total++; if (o_Eng_Valid !== 1'b0 || o_Eng_Key !== '0) $display("FAIL rst_eng: got v=%b key=%h want v=0 key=0", o_Eng_Valid, o_Eng_Key); else passed++;
    total++; if (o_Rsp_Valid !== 1'b0 || o_Rsp_Id !== '0 || o_Rsp_Data !== '0) $display("FAIL rst_rsp: got v=%b id=%0d data=%h want all 0", o_Rsp_Valid, o_Rsp_Id, o_Rsp_Data); else passed++;
    total++; if (o_Inflight !== 3'd0 || o_Upd_Grant !== 1'b0) $display("FAIL rst_state: got infl=%0d g=%b want 0 0", o_Inflight, o_Upd_Grant); else passed++;
    step();
    step();
    i_Req_Valid = '0;
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      total++; if (o_Rsp_Valid !== 1'b0) $display("FAIL rst_no_rsp k=%0d: got %b want 0", k, o_Rsp_Valid); else passed++;
    end
    total++; if (o_Inflight !== 3'd0) $display("FAIL rst_post_inflight: got %0d want 0", o_Inflight); else passed++;
  endtask

  initial begin
    passed = 0;
    total = 0;
    cyc = 0;
    rst = 1'b0;
    i_Req_Valid = '0;
    i_Upd_Req = 1'b0;
    i_Eng_Result = '0;
    for (int i = 0; i < NREQ; i++) i_Req_Key[i*KWID +: KWID] = key_of(i);
    test_reset();
    test_fairness();
    test_single();
    test_ptr_wrap();
    test_drain();
    test_abort();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
